// File: rtl/data_mem.sv
// data_mem: byte-addressed, little-endian, single-port synchronous data RAM.
// Stores use byte-lane enables derived from the access size and offset.
// Loads are right-aligned to lane 0 with the unused upper bytes zeroed.
// An access that crosses a word boundary is split into two word cycles
// (IDLE then SPLIT), or rejected with misErr when ALLOW_SPLIT is 0.
//
// Handshake: a request is taken on any rising edge where memReq = 1 and
// busy = 0. Requests seen while busy = 1 are dropped, not queued.
// rValid is a one-cycle pulse, and rData holds its value between pulses.
module data_mem #(
    parameter int SIZE        = 12,
    parameter int ALLOW_SPLIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memReq,
    input  logic            memWe,
    input  logic [1:0]      memSize,
    input  logic [SIZE-1:0] addr,
    input  logic [31:0]     wData,
    output logic [31:0]     rData,
    output logic            rValid,
    output logic            busy,
    output logic            misErr
);

    localparam int WW    = SIZE - 2;
    localparam int DEPTH = 1 << WW;
    localparam logic [WW-1:0] IDX_ONE = {{(WW-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    state_t state, state_next;

    // Storage, organised as four byte lanes per word.
    logic [3:0][7:0] mem [DEPTH];

    // Request decode.
    logic [1:0]      off;
    logic [WW-1:0]   word_idx;
    logic [3:0]      mask4;
    logic [2:0]      nbytes;
    logic            crossing;
    logic [7:0]      be8;
    logic [63:0]     wide_data;

    // State latched for the second half of a split access.
    logic [WW-1:0]   sp_idx;
    logic [3:0]      sp_be;
    logic [3:0][7:0] sp_data;
    logic            sp_we;
    logic [1:0]      sp_off;
    logic [3:0]      sp_mask;
    logic [31:0]     first_word;

    // RAM port control.
    logic [WW-1:0]   mem_idx;
    logic [3:0]      mem_be;
    logic [3:0][7:0] mem_wdata;
    logic            mem_wr;
    logic [31:0]     rd_word;

    // FSM decisions.
    logic            start_split;
    logic            reject;
    logic            load_done;
    logic [31:0]     load_data;
    logic [63:0]     merged;

    // Expand a 4-bit lane mask to a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    assign off      = addr[1:0];
    assign word_idx = addr[SIZE-1:2];

    // Access-size decode: byte, half, word (11 is treated as word).
    always_comb begin
        mask4  = 4'b1111;
        nbytes = 3'd4;
        case (memSize)
            2'b00:   begin mask4 = 4'b0001; nbytes = 3'd1; end
            2'b01:   begin mask4 = 4'b0011; nbytes = 3'd2; end
            default: begin mask4 = 4'b1111; nbytes = 3'd4; end
        endcase
    end

    // Offset 0..3 plus size 1..4 fits in 3 bits, so no overflow is possible.
    assign crossing = (({1'b0, off} + nbytes) > 3'd4);

    // Lanes and data across a two-word window: the low half belongs to word w
    // and the high half to word w+1. This single shift covers both halves.
    assign be8       = {4'b0000, mask4} << off;
    assign wide_data = {32'h0, wData} << {off, 3'b000};

    // The second half always targets the latched next word; index wraps at top.
    assign mem_idx = (state == S_SPLIT) ? sp_idx : word_idx;
    assign rd_word = mem[mem_idx];
    assign busy    = (state == S_SPLIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and RAM port control.
    always_comb begin
        state_next  = state;
        mem_be      = 4'b0000;
        mem_wdata   = '0;
        mem_wr      = 1'b0;
        start_split = 1'b0;
        reject      = 1'b0;
        load_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (memReq) begin
                    if (crossing && (ALLOW_SPLIT == 0)) begin
                        reject = 1'b1;
                    end else begin
                        mem_be    = be8[3:0];
                        mem_wdata = wide_data[31:0];
                        mem_wr    = memWe;
                        if (crossing) begin
                            start_split = 1'b1;
                            state_next  = S_SPLIT;
                        end else begin
                            load_done = !memWe;
                        end
                    end
                end
            end
            S_SPLIT: begin
                mem_be     = sp_be;
                mem_wdata  = sp_data;
                mem_wr     = sp_we;
                load_done  = !sp_we;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Load alignment: a single-word load shifts lane o down to lane 0, and a
    // split load shifts the {second, first} word pair so word w's bytes come first.
    always_comb begin
        merged    = {rd_word, first_word} >> {sp_off, 3'b000};
        load_data = (rd_word >> {off, 3'b000}) & lane_mask(mask4);
        if (state == S_SPLIT) begin
            load_data = merged[31:0] & lane_mask(sp_mask);
        end
    end

    // Capture the second half of a crossing access when it is accepted.
    always_ff @(posedge clk) begin
        if (start_split) begin
            sp_idx     <= word_idx + IDX_ONE;
            sp_be      <= be8[7:4];
            sp_data    <= wide_data[63:32];
            sp_we      <= memWe;
            sp_off     <= off;
            sp_mask    <= mask4;
            first_word <= rd_word;
        end
    end

    // Byte-lane RAM write. Reset suppresses the write, which is how a reset
    // during SPLIT aborts the second half while the first half stays committed.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][i] <= mem_wdata[i];
            end
        end
    end

    // Registered outputs: rData holds between loads; rValid and misErr pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rData  <= 32'h0;
            rValid <= 1'b0;
            misErr <= 1'b0;
        end else begin
            rValid <= load_done;
            misErr <= reject;
            if (load_done) rData <= load_data;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed tests for data_mem. The first instance allows split
// accesses, and the second (ALLOW_SPLIT = 0) covers rejection of crossing
// accesses.
module tb_data_mem;

    logic        clk;
    logic        rst;

    logic        req, we;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid, busy, miserr;

    logic        req_n, we_n;
    logic [1:0]  size_n;
    logic [11:0] addr_n;
    logic [31:0] wdata_n;
    logic [31:0] rdata_n;
    logic        rvalid_n, busy_n, miserr_n;

    int errors = 0;
    int checks = 0;

    data_mem #(.SIZE(12), .ALLOW_SPLIT(1)) dut (
        .clk(clk), .rst(rst), .memReq(req), .memWe(we), .memSize(size),
        .addr(addr), .wData(wdata), .rData(rdata), .rValid(rvalid),
        .busy(busy), .misErr(miserr)
    );

    data_mem #(.SIZE(12), .ALLOW_SPLIT(0)) dut_ns (
        .clk(clk), .rst(rst), .memReq(req_n), .memWe(we_n), .memSize(size_n),
        .addr(addr_n), .wData(wdata_n), .rData(rdata_n), .rValid(rvalid_n),
        .busy(busy_n), .misErr(miserr_n)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    // Drive one request at the falling edge and drop it after the accept
    // edge. Returns 1ns into cycle N+1.
    task automatic issue(input bit ns, input logic w, input logic [1:0] sz,
                         input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        if (ns) begin
            req_n = 1'b1; we_n = w; size_n = sz; addr_n = a; wdata_n = d;
        end else begin
            req = 1'b1; we = w; size = sz; addr = a; wdata = d;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        req_n = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 0; we = 0; size = 0; addr = 0; wdata = 0;
        req_n = 0; we_n = 0; size_n = 0; addr_n = 0; wdata_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want %h", rdata, 32'h0); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (miserr !== 1'b0) begin errors++; $display("FAIL rst_miserr: got %b want 0", miserr); end
        checks++; if (miserr_n !== 1'b0 || rvalid_n !== 1'b0) begin errors++; $display("FAIL rst_ns: got %b%b want 00", miserr_n, rvalid_n); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word();
        issue(0, 1, 2'b10, 12'h004, 32'hDEADBEEF);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL sw_no_rvalid: got %b want 0", rvalid); end
        issue(0, 0, 2'b10, 12'h004, 32'h0);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL lw4_rvalid: got %b want 1", rvalid); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw4_data: got %h want %h", rdata, 32'hDEADBEEF); end
        tick();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL lw4_pulse: got %b want 0", rvalid); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw4_hold: got %h want %h", rdata, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_lanes();
        issue(0, 1, 2'b00, 12'h006, 32'h000000AA);
        issue(0, 0, 2'b10, 12'h004, 32'h0);
        checks++; if (rdata !== 32'hDEAABEEF) begin errors++; $display("FAIL sb_merge: got %h want %h", rdata, 32'hDEAABEEF); end
        issue(0, 0, 2'b00, 12'h007, 32'h0);
        checks++; if (rdata !== 32'h000000DE) begin errors++; $display("FAIL lb7: got %h want %h", rdata, 32'h000000DE); end
        issue(0, 0, 2'b01, 12'h006, 32'h0);
        checks++; if (rdata !== 32'h0000DEAA) begin errors++; $display("FAIL lh6: got %h want %h", rdata, 32'h0000DEAA); end
    endtask

    task automatic test_split();
        issue(0, 1, 2'b10, 12'h00E, 32'h11223344);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ssw_busy: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ssw_busy_end: got %b want 0", busy); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL ssw_no_rvalid: got %b want 0", rvalid); end
        issue(0, 0, 2'b10, 12'h00E, 32'h0);
        checks++; if (busy !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL slw_n1: got busy=%b rvalid=%b want 1 0", busy, rvalid); end
        tick();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL slw_rvalid: got %b want 1", rvalid); end
        checks++; if (rdata !== 32'h11223344) begin errors++; $display("FAIL slw_data: got %h want %h", rdata, 32'h11223344); end
        issue(0, 0, 2'b00, 12'h00F, 32'h0);
        checks++; if (rdata !== 32'h00000033) begin errors++; $display("FAIL lb_f: got %h want %h", rdata, 32'h00000033); end
        issue(0, 0, 2'b00, 12'h011, 32'h0);
        checks++; if (rdata !== 32'h00000011) begin errors++; $display("FAIL lb_11: got %h want %h", rdata, 32'h00000011); end
        issue(0, 0, 2'b10, 12'h010, 32'h0);
        checks++; if (rdata[15:0] !== 16'h1122) begin errors++; $display("FAIL lw10_low: got %h want %h", rdata[15:0], 16'h1122); end
    endtask

    task automatic test_busy_ignore();
        issue(0, 1, 2'b10, 12'h040, 32'h01020304);
        issue(0, 1, 2'b10, 12'h02E, 32'h55667788);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 12'h040; wdata = 32'hFFFFFFFF;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
        @(posedge clk);
        #1;
        req = 1'b0;
        issue(0, 0, 2'b10, 12'h040, 32'h0);
        checks++; if (rdata !== 32'h01020304) begin errors++; $display("FAIL ign_word: got %h want %h", rdata, 32'h01020304); end
        issue(0, 0, 2'b01, 12'h030, 32'h0);
        checks++; if (rdata !== 32'h00005566) begin errors++; $display("FAIL split_hi: got %h want %h", rdata, 32'h00005566); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 12'h004;
        @(posedge clk);
        #1;
        size = 2'b00; addr = 12'h007;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEAABEEF) begin errors++; $display("FAIL b2b_first: got %b %h want 1 %h", rvalid, rdata, 32'hDEAABEEF); end
        @(posedge clk);
        #1;
        req = 1'b0;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h000000DE) begin errors++; $display("FAIL b2b_second: got %b %h want 1 %h", rvalid, rdata, 32'h000000DE); end
        issue(0, 1, 2'b10, 12'h050, 32'hCAFEF00D);
        issue(0, 0, 2'b10, 12'h050, 32'h0);
        checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL raw: got %h want %h", rdata, 32'hCAFEF00D); end
    endtask

    task automatic test_wrap();
        issue(0, 1, 2'b01, 12'hFFF, 32'h0000BEEF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy: got %b want 1", busy); end
        tick();
        issue(0, 0, 2'b00, 12'hFFF, 32'h0);
        checks++; if (rdata !== 32'h000000EF) begin errors++; $display("FAIL wrap_top: got %h want %h", rdata, 32'h000000EF); end
        issue(0, 0, 2'b00, 12'h000, 32'h0);
        checks++; if (rdata !== 32'h000000BE) begin errors++; $display("FAIL wrap_zero: got %h want %h", rdata, 32'h000000BE); end
        issue(0, 0, 2'b01, 12'hFFF, 32'h0);
        tick();
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0000BEEF) begin errors++; $display("FAIL wrap_lh: got %b %h want 1 %h", rvalid, rdata, 32'h0000BEEF); end
    endtask

    task automatic test_reset_split();
        issue(0, 1, 2'b10, 12'h00D, 32'hAABBCCDD);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (rdata !== 32'h0 || rvalid !== 1'b0 || busy !== 1'b0 || miserr !== 1'b0) begin errors++; $display("FAIL rs_outputs: got %h %b %b %b want 0 0 0 0", rdata, rvalid, busy, miserr); end
        issue(0, 0, 2'b00, 12'h00D, 32'h0);
        checks++; if (rdata !== 32'h000000DD) begin errors++; $display("FAIL rs_d: got %h want %h", rdata, 32'h000000DD); end
        issue(0, 0, 2'b01, 12'h00E, 32'h0);
        checks++; if (rdata !== 32'h0000BBCC) begin errors++; $display("FAIL rs_ef: got %h want %h", rdata, 32'h0000BBCC); end
        issue(0, 0, 2'b00, 12'h010, 32'h0);
        checks++; if (rdata !== 32'h00000022) begin errors++; $display("FAIL rs_10: got %h want %h", rdata, 32'h00000022); end
    endtask

    task automatic test_nosplit();
        issue(1, 1, 2'b10, 12'h000, 32'h03020100);
        issue(1, 1, 2'b10, 12'h004, 32'h07060504);
        issue(1, 0, 2'b01, 12'h003, 32'h0);
        checks++; if (miserr_n !== 1'b1 || rvalid_n !== 1'b0 || busy_n !== 1'b0) begin errors++; $display("FAIL ns_lh: got mis=%b rv=%b busy=%b want 1 0 0", miserr_n, rvalid_n, busy_n); end
        tick();
        checks++; if (miserr_n !== 1'b0) begin errors++; $display("FAIL ns_pulse: got %b want 0", miserr_n); end
        issue(1, 1, 2'b01, 12'h003, 32'h0000FFFF);
        checks++; if (miserr_n !== 1'b1) begin errors++; $display("FAIL ns_sh: got %b want 1", miserr_n); end
        issue(1, 0, 2'b10, 12'h000, 32'h0);
        checks++; if (rdata_n !== 32'h03020100) begin errors++; $display("FAIL ns_w0: got %h want %h", rdata_n, 32'h03020100); end
        issue(1, 0, 2'b10, 12'h004, 32'h0);
        checks++; if (rdata_n !== 32'h07060504) begin errors++; $display("FAIL ns_w1: got %h want %h", rdata_n, 32'h07060504); end
        issue(1, 0, 2'b01, 12'h002, 32'h0);
        checks++; if (rvalid_n !== 1'b1 || rdata_n !== 32'h00000302) begin errors++; $display("FAIL ns_lh2: got %b %h want 1 %h", rvalid_n, rdata_n, 32'h00000302); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_split();
        test_busy_ignore();
        test_back_to_back();
        test_wrap();
        test_reset_split();
        test_nosplit();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressed, little-endian, single-port synchronous data RAM that sits directly downstream of the memory controller. It consumes the controller's `addrOut` and `dataWO`, and returns the raw word that the controller sign- or zero-extends on `dataRI`. It applies byte-lane write enables from the access size, right-aligns read data to lane 0, and serialises word-crossing (misaligned) accesses into two word cycles through a small state machine.

## Interface

**Parameters**
- `SIZE`, default 12: address width in bytes. Depth is 2^(SIZE-2) words of 32 bits.
- `ALLOW_SPLIT`, default 1: 1 splits word-crossing accesses; 0 rejects them with `misErr`.

**Ports**
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `memReq` input 1: access request, sampled only when `busy` = 0.
- `memWe` input 1: 1 = store, 0 = load.
- `memSize` input 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `addr` input SIZE: byte address (memory controller `addrOut`).
- `wData` input 32: store data, right-aligned in lane 0 (memory controller `dataWO`).
- `rData` output 32: load data, right-aligned; unused upper bytes are 0 (feeds the memory controller `dataRI`).
- `rValid` output 1: one-cycle pulse; `rData` is valid in this cycle.
- `busy` output 1: high during the second half of a split access; upstream must stall.
- `misErr` output 1: one-cycle pulse when a crossing access is rejected (`ALLOW_SPLIT` = 0).

## Operation

- **Offset and word index.** Offset `o` = `addr[1:0]`, `nb` = 1/2/4 bytes, word index `w` = `addr[SIZE-1:2]`. An access crosses when `o + nb > 4`.
- **Write lanes.** For a non-crossing store, byte i of `wData` goes to lane `o+i` of word `w`. Only those lanes are written; the other lanes keep their contents.
- **Read alignment.** For a non-crossing load, lanes `o .. o+nb-1` of word `w` are shifted down to `rData[8*nb-1:0]`, and the upper bytes are zeroed.
- **States:**
  - IDLE: accepts requests.
  - SPLIT: second word of a crossing access.
- **IDLE, `memReq` = 1, non-crossing:**
  - A store commits at this edge.
  - A load reads word `w`; `rValid` pulses next cycle.
  - The state stays IDLE.
- **IDLE, `memReq` = 1, crossing, `ALLOW_SPLIT` = 1:**
  - The first word `w` is accessed for lanes `o..3` (stores write them; loads latch them).
  - The request is latched, and the state goes to SPLIT.
- **SPLIT:**
  - `busy` = 1.
  - Word (`w`+1) mod depth is accessed for lanes 0..(`o+nb-5`).
  - A load merges the two parts into `rData` (bytes from word `w` first).
  - The state returns to IDLE.
- **Crossing with `ALLOW_SPLIT` = 0:** no memory change, no `rValid`; `misErr` pulses next cycle.
- **Ignored requests.** `memReq` while `busy` = 1 is ignored, not queued. `memReq` = 0 causes no access and no pulses.
- **Wrap-around.** Word index top+1 wraps to word 0. For example, a halfword at byte 2^SIZE−1 uses the last byte and byte 0.
- **Read-after-write.** A load accepted the cycle after a store to the same bytes returns the new data.
- **Reset:**
  - State goes to IDLE; `rData` = 0, `rValid` = 0, `busy` = 0, `misErr` = 0.
  - RAM contents are not cleared.
  - Reset in SPLIT aborts the second half. The first-half store stays committed, and no `rValid` is produced for a load.

## Timing

- **Non-crossing load:** latency 1. Accept at edge N; `rValid` = 1 and `rData` valid during cycle N+1.
- **Crossing load:** latency 2. Accept at N; `busy` = 1 in cycle N+1; `rValid` in cycle N+2.
- **Stores:** no `rValid`.
  - Non-crossing stores commit at the accept edge.
  - Crossing stores commit the first part at N and the second at N+1, with `busy` = 1 in cycle N+1.
- **Back-to-back requests.** A new request is accepted in the same cycle `rValid` is high, giving full throughput for non-crossing accesses.
- **Output hold.**
  - `rData` holds its last value when `rValid` = 0.
  - `busy` is a decode of the state register.
  - `misErr` is registered, asserted in cycle N+1 only.

## Test plan

- SW 0xDEADBEEF @0x004, then LW @0x004 → `rValid` 1 cycle after accept, `rData` = 0xDEADBEEF.
- Next, SB 0x000000AA @0x006, then LW @0x004 → 0xDEAABEEF. LB @0x007 → `rData` = 0x000000DE.
- Crossing SW 0x11223344 @0x00E → `busy` high 1 cycle; bytes 0x00E..0x011 = 44,33,22,11. LW @0x00E → `rValid` 2 cycles after accept, `rData` = 0x11223344. LW @0x010 → 0x????1122 with low half 0x1122.
- Wrap: SH 0x0000BEEF @0xFFF (SIZE = 12) → byte 0xFFF = 0xEF, byte 0x000 = 0xBE. LH @0xFFF → 0x0000BEEF.
- `ALLOW_SPLIT` = 0: LH @0x003 → `misErr` pulse next cycle, `rValid` = 0. SH @0x003 → words 0 and 1 unchanged.
- Reset in SPLIT of SW 0xAABBCCDD @0x00D → byte 0x00D..0x00F = DD,CC,BB; byte 0x010 unchanged. All outputs 0 the cycle after `rst`. A `memReq` during `busy` causes no access.
